serial_tx_shifter: RTL and testbench
====================================

SERIAL_TX_SHIFTER -- requirements
Module: serial_tx_shifter

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have port start, input, 1 bit: request to transmit pi; sampled only in IDLE or DONE.
REQ-004 The block SHALL have port pi, input, 8 bits: parallel byte, captured on the accepted start edge.
REQ-005 The block SHALL have port so, output, 1 bit: serial data, LSB first; 0 whenever sv is 0.
REQ-006 The block SHALL have port sv, output, 1 bit: serial-valid, one bit per cycle; drives the far-end shift and count enables.
REQ-007 The block SHALL have port last, output, 1 bit: high with sv on the final transmitted bit of a frame.
REQ-008 The block SHALL have port busy, output, 1 bit: high in SHIFT and PARITY states.
REQ-009 The block SHALL have port done, output, 1 bit: single-cycle pulse in DONE state.

Function
REQ-010 The block SHALL hold an 8-bit shift register sh, a 3-bit bit counter cnt, and an FSM with states IDLE, SHIFT, PARITY, DONE.
REQ-011 In IDLE or DONE, start=1 at an edge SHALL load sh<=pi and cnt<=0, capture the parity byte, and enter SHIFT.
REQ-012 In IDLE or DONE, start=0 SHALL lead to IDLE; start is ignored in SHIFT and PARITY.
REQ-013 In SHIFT, the block SHALL drive sv=1 and so=sh[0], then shift right with a 0 fill and increment cnt each edge.
REQ-014 In SHIFT with cnt=7, the next state SHALL be PARITY when parity is compiled in, else DONE; cnt wraps 7->0.
REQ-015 The first data bit SHALL appear in the cycle after the accepting edge; 8 data bits SHALL occupy 8 consecutive cycles with no gaps.
REQ-016 In DONE, the block SHALL drive done=1, sv=0, so=0, and busy=0.
REQ-017 A start during DONE SHALL begin the next frame with exactly one non-sv cycle between frames.
REQ-018 Outputs so, sv, last, busy, and done SHALL be decoded from registered state only, with no combinational path from start or pi.
REQ-019 A change of pi after the load edge SHALL have no effect on the frame in flight.

Reset
REQ-020 rst_n=0 SHALL force, immediately and independently of clk: state=IDLE, sh=0, cnt=0, parity reg=0, so=0, sv=0, last=0, busy=0, done=0.
REQ-021 Reset mid-frame SHALL abort the frame with no done pulse; the first edge after release with start=1 starts a fresh frame.

Configuration
REQ-022 Macro SERIAL_TX_PARITY_EN defined: PARITY state SHALL follow SHIFT for one cycle with sv=1, so=XOR of loaded byte (even parity), last=1; data bit 7 has last=0.
REQ-023 Macro SERIAL_TX_PARITY_EN undefined: PARITY state and parity register SHALL be absent; last=1 on data bit 7; frame = 8 sv cycles.

Verification
REQ-024 Reset, then pi=8'hA5 with a one-cycle start: so over the 8 sv cycles = 1,0,1,0,0,1,0,1; last on the 8th; done in the following cycle; busy high for exactly 8 cycles (parity off).
REQ-025 With SERIAL_TX_PARITY_EN defined, pi=8'hA5 -> 9th sv bit so=0; pi=8'h07 -> 9th bit so=1; last only on the 9th; done one cycle later.
REQ-026 Start held high with pi=8'h3C then 8'hC3 changed at done: two back-to-back frames, one sv=0 cycle between; second frame = 1,1,0,0,0,0,1,1.
REQ-027 Start pulsed in the 3rd sv cycle of a frame with pi=8'hFF: the frame in flight is unaltered and no extra frame follows.
REQ-028 rst_n pulled low in the 5th sv cycle of a frame: sv, so, and busy drop to 0 without waiting for clk; no done pulse; a new start after release transmits its byte correctly.

Source files
------------

// File: rtl/serial_tx_shifter.sv
// -----------------------------------------------------------------------------
// serial_tx_shifter
//
// Purpose
//   Serialises one parallel byte per frame, LSB first, one bit per clock.
//   A frame is accepted on a rising edge where start=1 while the block is in
//   IDLE or DONE. Eight data bits then follow on consecutive cycles. When the
//   build enables it, an even-parity bit follows the data bits. A single-cycle
//   done pulse closes the frame.
//
// Configuration
//   SERIAL_TX_PARITY_EN  When this macro is defined, a PARITY state and a
//                        parity register are built in. The frame is then
//                        9 sv cycles long and last marks the parity bit.
//                        When the macro is not defined, the frame is 8 sv
//                        cycles long and last marks data bit 7.
//
// Ports
//   clk    in   1  Single clock. All state updates on its rising edge.
//   rst_n  in   1  Asynchronous active-low reset.
//   start  in   1  Request to transmit pi. Sampled only in IDLE or DONE.
//   pi     in   8  Parallel byte. Captured on the accepting edge.
//   so     out  1  Serial data, LSB first. 0 whenever sv is 0.
//   sv     out  1  Serial-valid. High for each transmitted bit.
//   last   out  1  High together with sv on the final bit of a frame.
//   busy   out  1  High in SHIFT and PARITY.
//   done   out  1  Single-cycle pulse in DONE.
// -----------------------------------------------------------------------------
module serial_tx_shifter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] pi,
    output logic       so,
    output logic       sv,
    output logic       last,
    output logic       busy,
    output logic       done
);

`ifdef SERIAL_TX_PARITY_EN
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        DONE   = 2'd2,
        PARITY = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        DONE   = 2'd2
    } state_t;
`endif

    state_t     state;
    logic [7:0] sh;
    logic [2:0] cnt;
`ifdef SERIAL_TX_PARITY_EN
    logic       par;
`endif

    // NOTE: state registers use non-blocking (<=) assignments. Every
    // register therefore samples pre-edge values. This matters because the
    // shift, the count and the state transition all read cnt/sh in the same
    // edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sh    <= '0;
            cnt   <= '0;
`ifdef SERIAL_TX_PARITY_EN
            par   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        sh    <= pi;
                        cnt   <= '0;
`ifdef SERIAL_TX_PARITY_EN
                        par   <= ^pi;   // even parity of the loaded byte
`endif
                        state <= SHIFT;
                    end else begin
                        state <= IDLE;
                    end
                end
                SHIFT: begin
                    sh  <= {1'b0, sh[7:1]};
                    cnt <= cnt + 3'd1;  // wraps 7 -> 0 on the final bit
                    if (cnt == 3'd7) begin
`ifdef SERIAL_TX_PARITY_EN
                        state <= PARITY;
`else
                        state <= DONE;
`endif
                    end
                end
`ifdef SERIAL_TX_PARITY_EN
                PARITY: state <= DONE;
`endif
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs are decoded from registered state only. They therefore have no
    // path from start/pi. Because the registers clear asynchronously, the
    // outputs also drop as soon as rst_n falls.
    // NOTE: every output gets a default before the case statement. Without
    // those defaults the combinational block would infer latches.
    always_comb begin
        so   = 1'b0;
        sv   = 1'b0;
        last = 1'b0;
        busy = 1'b0;
        done = 1'b0;
        case (state)
            SHIFT: begin
                sv   = 1'b1;
                busy = 1'b1;
                so   = sh[0];
`ifndef SERIAL_TX_PARITY_EN
                last = (cnt == 3'd7);
`endif
            end
`ifdef SERIAL_TX_PARITY_EN
            PARITY: begin
                sv   = 1'b1;
                busy = 1'b1;
                so   = par;
                last = 1'b1;
            end
`endif
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_serial_tx_shifter.sv
// -----------------------------------------------------------------------------
// tb_serial_tx_shifter
//
// Self-checking bench for serial_tx_shifter. The DUT is compiled with the same
// SERIAL_TX_PARITY_EN setting as the bench. Inputs change on the falling edge.
// Outputs are sampled on the falling edge, half a cycle after each rising edge.
// The expected bit sequence of a frame is built from the byte value with
// plain arithmetic.
// -----------------------------------------------------------------------------
module tb_serial_tx_shifter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] pi;
    logic       so, sv, last, busy, done;

    int tests = 0;
    int fails = 0;

    serial_tx_shifter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .pi    (pi),
        .so    (so),
        .sv    (sv),
        .last  (last),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_quiet(input string tag, input logic exp_done);
        check({tag, ".sv"},   8'(sv),   8'h0);
        check({tag, ".so"},   8'(so),   8'h0);
        check({tag, ".last"}, 8'(last), 8'h0);
        check({tag, ".busy"}, 8'(busy), 8'h0);
        check({tag, ".done"}, 8'(done), 8'(exp_done));
    endtask

    // The frame is accepted on the next rising edge. The task returns at the
    // falling edge where the first data bit is visible.
    task automatic start_frame(input logic [7:0] b);
        @(negedge clk);
        pi    = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        pi    = 8'($urandom);
    endtask

    // Checks every sv cycle of a frame carrying byte b. The task is entered
    // at the falling edge of the first bit.
    //   pulse_at    sv-cycle index where start is pulsed with pi=FF (-1: none)
    //   keep_start  hold start high throughout
    //   abort_at    sv-cycle index where rst_n is pulled low (-1: none)
    // Without an abort, the task returns at the falling edge of the DONE cycle.
    task automatic check_frame(input logic [7:0] b, input int pulse_at,
                               input bit keep_start, input int abort_at,
                               input string tag);
        bit exp_q[$];
        int n;
        for (int k = 0; k < 8; k++) exp_q.push_back(bit'((b >> k) & 8'h1));
`ifdef SERIAL_TX_PARITY_EN
        exp_q.push_back(bit'($countones(b) % 2));
`endif
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            string t;
            t = $sformatf("%s.b%0d", tag, i);
            check({t, ".sv"},   8'(sv),   8'h1);
            check({t, ".so"},   8'(so),   8'(exp_q[i]));
            check({t, ".last"}, 8'(last), 8'(i == n - 1));
            check({t, ".busy"}, 8'(busy), 8'h1);
            check({t, ".done"}, 8'(done), 8'h0);
            if (i == abort_at) begin
                #2 rst_n = 1'b0;
                #1 check_quiet({tag, ".rst_async"}, 1'b0);
                @(posedge clk);
                @(posedge clk);
                #1 check_quiet({tag, ".rst_held"}, 1'b0);
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            start = keep_start || (i == pulse_at);
            pi    = (i == pulse_at) ? 8'hFF : 8'($urandom);
            @(negedge clk);
        end
        check_quiet({tag, ".done"}, 1'b1);
    endtask

    initial begin
        logic [7:0] b;

        rst_n = 1'b1;
        start = 1'b0;
        pi    = 8'h00;
        #1 rst_n = 1'b0;
        #2 check_quiet("reset_async", 1'b0);
        repeat (2) @(posedge clk);
        #1 check_quiet("reset_held", 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_quiet("idle", 1'b0);

        // Directed byte A5. With parity disabled the frame must be
        // 1,0,1,0,0,1,0,1.
        start_frame(8'hA5);
        check_frame(8'hA5, -1, 1'b0, -1, "a5");
        @(negedge clk);
        check_quiet("a5.after_done", 1'b0);

`ifdef SERIAL_TX_PARITY_EN
        start_frame(8'h07);
        check_frame(8'h07, -1, 1'b0, -1, "p07");
`endif

        // Back-to-back frames with start held high. pi changes to C3 at DONE.
        start_frame(8'h3C);
        start = 1'b1;
        check_frame(8'h3C, -1, 1'b1, -1, "b2b1");
        pi = 8'hC3;
        @(negedge clk);
        start = 1'b0;
        pi    = 8'($urandom);
        check_frame(8'hC3, -1, 1'b0, -1, "b2b2");

        // A start pulse during the third sv cycle must neither disturb the
        // frame nor trigger another one.
        b = 8'($urandom);
        start_frame(b);
        check_frame(b, 2, 1'b0, -1, "ignore");
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_quiet($sformatf("ignore.idle%0d", k), 1'b0);
        end

        // Random frames. pi is scrambled every cycle while a frame is in
        // flight.
        for (int r = 0; r < 6; r++) begin
            b = 8'($urandom);
            start_frame(b);
            check_frame(b, -1, 1'b0, -1, $sformatf("rnd%0d", r));
        end

        // Reset during the fifth sv cycle. Bit 4 is forced high so that so
        // visibly drops when reset asserts.
        b = 8'($urandom) | 8'h10;
        start_frame(b);
        check_frame(b, -1, 1'b0, 4, "abort");
        @(negedge clk);
        check_quiet("abort.idle", 1'b0);
        b = 8'($urandom);
        start_frame(b);
        check_frame(b, -1, 1'b0, -1, "post_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
